// File: rtl/bayer_demosaic_param.sv
`timescale 1ns/1ps
// Bilinear Bayer demosaic: streams a raw CFA frame into external R/G/B memories,
// then fills in the two missing colours at every pixel using mirrored borders.
module bayer_demosaic_param #(
    parameter int DW = 8,
    parameter int XW = 7,
    parameter int YW = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_en,
    input  logic [DW-1:0]        data_in,
    input  logic [1:0]           cfa_mode,
    output logic                 wr_r,
    output logic                 wr_g,
    output logic                 wr_b,
    output logic [XW+YW-1:0]     addr_r,
    output logic [XW+YW-1:0]     addr_g,
    output logic [XW+YW-1:0]     addr_b,
    output logic [DW-1:0]        wdata_r,
    output logic [DW-1:0]        wdata_g,
    output logic [DW-1:0]        wdata_b,
    input  logic [DW-1:0]        rdata_r,
    input  logic [DW-1:0]        rdata_g,
    input  logic [DW-1:0]        rdata_b,
    output logic                 busy,
    output logic                 done
);
    localparam int AW = XW + YW;
    localparam logic [AW-1:0] P11 = AW'((1 << XW) | 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RD, S_WR, S_FIN} state_t;

    state_t          r_state, w_next;
    logic [AW-1:0]   r_cnt;
    logic [1:0]      r_k, r_mode;
    logic            r_ld_wr;
    logic [1:0]      r_ld_ch;
    logic [AW-1:0]   r_ld_addr;
    logic [DW-1:0]   r_ld_data, r_p11;
    logic [DW+1:0]   r_acc_r, r_acc_g, r_acc_b;

    logic [XW-1:0]   w_x, w_xm, w_xp;
    logic [YW-1:0]   w_y, w_ym, w_yp;
    logic [1:0]      w_site, w_last_k, w_ld_mode, w_ld_site;
    logic            w_ctr_g, w_row_r, w_accept;
    logic [AW-1:0]   w_cross, w_diag, w_hz, w_vt, w_ra_r, w_ra_g, w_ra_b;
    logic [DW-1:0]   w_rd_r, w_rd_g, w_rd_b, w_res_r, w_res_g, w_res_b;

    function automatic logic [1:0] site(input logic x0, input logic y0, input logic [1:0] m);
        logic px, py;
        px = x0 ^ m[0];
        py = y0 ^ m[1];
        if (!px && !py) return 2'd0;
        if (px && py) return 2'd2;
        return 2'd1;
    endfunction

    function automatic logic [XW-1:0] mir_x(input logic [XW-1:0] c, input logic up);
        if (up) return (c == {XW{1'b1}}) ? c - XW'(1) : c + XW'(1);
        return (c == '0) ? XW'(1) : c - XW'(1);
    endfunction

    function automatic logic [YW-1:0] mir_y(input logic [YW-1:0] c, input logic up);
        if (up) return (c == {YW{1'b1}}) ? c - YW'(1) : c + YW'(1);
        return (c == '0) ? YW'(1) : c - YW'(1);
    endfunction

    function automatic logic [DW-1:0] rnd4(input logic [DW+1:0] s);
        logic [DW+1:0] t;
        t = s + (DW+2)'(2);
        return DW'(t >> 2);
    endfunction

    function automatic logic [DW-1:0] rnd2(input logic [DW+1:0] s);
        logic [DW+1:0] t;
        t = s + (DW+2)'(1);
        return DW'(t >> 1);
    endfunction

    assign w_x       = r_cnt[XW-1:0];
    assign w_y       = r_cnt[AW-1:XW];
    assign w_xm      = mir_x(w_x, 1'b0);
    assign w_xp      = mir_x(w_x, 1'b1);
    assign w_ym      = mir_y(w_y, 1'b0);
    assign w_yp      = mir_y(w_y, 1'b1);
    assign w_site    = site(w_x[0], w_y[0], r_mode);
    assign w_ctr_g   = (w_site == 2'd1);
    assign w_row_r   = ~(w_y[0] ^ r_mode[1]);
    assign w_last_k  = w_ctr_g ? 2'd1 : 2'd3;
    assign w_accept  = in_en && (r_state == S_IDLE || r_state == S_FIN || r_state == S_LOAD);
    assign w_ld_mode = (r_state == S_LOAD) ? r_mode : cfa_mode;
    assign w_ld_site = site(r_cnt[0], r_cnt[XW], w_ld_mode);

    // The last load strobe shares the first read cycle of centre 0; the only read it can
    // displace is the diagonal (1,1), so that pixel is kept aside during load.
    assign w_rd_r = (r_ld_wr && r_ld_ch == 2'd0) ? r_p11 : rdata_r;
    assign w_rd_g = (r_ld_wr && r_ld_ch == 2'd1) ? r_p11 : rdata_g;
    assign w_rd_b = (r_ld_wr && r_ld_ch == 2'd2) ? r_p11 : rdata_b;

    assign w_res_r = w_ctr_g ? rnd2(r_acc_r) : rnd4(r_acc_r);
    assign w_res_g = rnd4(r_acc_g);
    assign w_res_b = w_ctr_g ? rnd2(r_acc_b) : rnd4(r_acc_b);

    always_comb begin
        case (r_k)
            2'd0:    begin w_cross = {w_ym, w_x};  w_diag = {w_ym, w_xm}; end
            2'd1:    begin w_cross = {w_y,  w_xm}; w_diag = {w_ym, w_xp}; end
            2'd2:    begin w_cross = {w_y,  w_xp}; w_diag = {w_yp, w_xm}; end
            default: begin w_cross = {w_yp, w_x};  w_diag = {w_yp, w_xp}; end
        endcase
        w_hz   = (r_k == 2'd0) ? {w_y, w_xm} : {w_y, w_xp};
        w_vt   = (r_k == 2'd0) ? {w_ym, w_x} : {w_yp, w_x};
        w_ra_r = '0;
        w_ra_g = '0;
        w_ra_b = '0;
        if (!w_ctr_g) begin
            w_ra_g = w_cross;
            if (w_site == 2'd0) w_ra_b = w_diag;
            else                w_ra_r = w_diag;
        end else if (w_row_r) begin
            w_ra_r = w_hz;
            w_ra_b = w_vt;
        end else begin
            w_ra_b = w_hz;
            w_ra_r = w_vt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_FIN: if (in_en) w_next = S_LOAD;
            S_LOAD:        if (in_en && r_cnt == '1) w_next = S_RD;
            S_RD:          if (r_k == w_last_k) w_next = S_WR;
            S_WR:          w_next = (r_cnt == '1) ? S_FIN : S_RD;
            default:       w_next = S_IDLE;
        endcase
    end

    always_comb begin
        wr_r    = 1'b0;  wr_g    = 1'b0;  wr_b    = 1'b0;
        addr_r  = '0;    addr_g  = '0;    addr_b  = '0;
        wdata_r = '0;    wdata_g = '0;    wdata_b = '0;
        busy    = (r_state == S_LOAD) || (r_state == S_RD) || (r_state == S_WR);
        done    = (r_state == S_FIN);
        if (r_state == S_RD) begin
            addr_r = w_ra_r;
            addr_g = w_ra_g;
            addr_b = w_ra_b;
        end
        if (r_state == S_WR) begin
            if (w_site != 2'd0) begin wr_r = 1'b1; addr_r = r_cnt; wdata_r = w_res_r; end
            if (w_site != 2'd1) begin wr_g = 1'b1; addr_g = r_cnt; wdata_g = w_res_g; end
            if (w_site != 2'd2) begin wr_b = 1'b1; addr_b = r_cnt; wdata_b = w_res_b; end
        end
        if (r_ld_wr) begin
            case (r_ld_ch)
                2'd0:    begin wr_r = 1'b1; addr_r = r_ld_addr; wdata_r = r_ld_data; end
                2'd1:    begin wr_g = 1'b1; addr_g = r_ld_addr; wdata_g = r_ld_data; end
                default: begin wr_b = 1'b1; addr_b = r_ld_addr; wdata_b = r_ld_data; end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_k       <= '0;
            r_mode    <= '0;
            r_ld_wr   <= 1'b0;
            r_ld_ch   <= '0;
            r_ld_addr <= '0;
            r_acc_r   <= '0;
            r_acc_g   <= '0;
            r_acc_b   <= '0;
        end else begin
            r_ld_wr <= w_accept;
            if (w_accept) begin
                r_ld_ch   <= w_ld_site;
                r_ld_addr <= r_cnt;
                if (r_state != S_LOAD) r_mode <= cfa_mode;
            end
            // The counter wraps to 0 after the last pixel, leaving the centre at pixel 0.
            if (w_accept || r_state == S_WR) r_cnt <= r_cnt + AW'(1);
            if (r_state == S_RD) begin
                r_k     <= (r_k == w_last_k) ? 2'd0 : r_k + 2'd1;
                r_acc_r <= r_acc_r + (DW+2)'(w_rd_r);
                r_acc_g <= r_acc_g + (DW+2)'(w_rd_g);
                r_acc_b <= r_acc_b + (DW+2)'(w_rd_b);
            end else begin
                r_k     <= '0;
                r_acc_r <= '0;
                r_acc_g <= '0;
                r_acc_b <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_ld_data <= data_in;
            if (r_cnt == P11) r_p11 <= data_in;
        end
    end
endmodule

// File: tb/tb_bayer_demosaic_param.sv
`timescale 1ns/1ps
// Randomised frame bench for bayer_demosaic_param on a 4x4 frame, checked against a
// neighbourhood-averaging model of the demosaic and a scoreboard of expected strobes.
module tb_bayer_demosaic_param;
    localparam int DW = 8;
    localparam int XW = 2;
    localparam int YW = 2;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int N  = 16;

    logic       clk = 1'b0;
    logic       reset, in_en;
    logic [7:0] data_in;
    logic [1:0] cfa_mode;
    logic       wr_r, wr_g, wr_b, busy, done;
    logic [3:0] addr_r, addr_g, addr_b;
    logic [7:0] wdata_r, wdata_g, wdata_b, rdata_r, rdata_g, rdata_b;
    logic [7:0] mem_r [16];
    logic [7:0] mem_g [16];
    logic [7:0] mem_b [16];

    typedef struct {
        int cyc;
        int mask;
        int addr;
        int dr;
        int dg;
        int db;
    } rec_t;

    rec_t q[$];
    rec_t cur;
    int   raw [16];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bayer_demosaic_param #(.DW(DW), .XW(XW), .YW(YW)) dut (
        .clk(clk), .reset(reset), .in_en(in_en), .data_in(data_in), .cfa_mode(cfa_mode),
        .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b),
        .addr_r(addr_r), .addr_g(addr_g), .addr_b(addr_b),
        .wdata_r(wdata_r), .wdata_g(wdata_g), .wdata_b(wdata_b),
        .rdata_r(rdata_r), .rdata_g(rdata_g), .rdata_b(rdata_b),
        .busy(busy), .done(done)
    );

    assign rdata_r = mem_r[addr_r];
    assign rdata_g = mem_g[addr_g];
    assign rdata_b = mem_b[addr_b];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_r) mem_r[addr_r] <= wdata_r;
        if (wr_g) mem_g[addr_g] <= wdata_g;
        if (wr_b) mem_b[addr_b] <= wdata_b;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int col(input int x, input int y, input int m);
        int px, py;
        px = (x & 1) ^ (m & 1);
        py = (y & 1) ^ ((m >> 1) & 1);
        if (px == 0 && py == 0) return 0;
        if (px == 1 && py == 1) return 2;
        return 1;
    endfunction

    function automatic int mir(input int c, input int lim);
        if (c < 0) return 1;
        if (c >= lim) return lim - 2;
        return c;
    endfunction

    // Channel c at (x,y): native sample, or the rounded mean of the 8-neighbour slots
    // (mirrored at the border) whose CFA colour is c.
    function automatic int model_val(input int x, input int y, input int c, input int m);
        int sum, n, mx, my;
        if (col(x, y, m) == c) return raw[y*W + x];
        sum = 0;
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
                if (dx == 0 && dy == 0) continue;
                mx = mir(x + dx, W);
                my = mir(y + dy, H);
                if (col(mx, my, m) == c) begin
                    sum += raw[my*W + mx];
                    n++;
                end
            end
        return (sum + n/2) / n;
    endfunction

    always @(negedge clk) begin
        if (wr_r || wr_g || wr_b) begin
            if (q.size() == 0) chk("unexpected_strobe", int'({wr_b, wr_g, wr_r}), 0);
            else begin
                cur = q.pop_front();
                chk("strobe_cycle", cyc, cur.cyc);
                chk("strobe_mask", int'({wr_b, wr_g, wr_r}), cur.mask);
                if (wr_r) begin chk("addr_r", int'(addr_r), cur.addr); chk("wdata_r", int'(wdata_r), cur.dr); end
                if (wr_g) begin chk("addr_g", int'(addr_g), cur.addr); chk("wdata_g", int'(wdata_g), cur.dg); end
                if (wr_b) begin chk("addr_b", int'(addr_b), cur.addr); chk("wdata_b", int'(wdata_b), cur.db); end
            end
        end else if (q.size() > 0 && q[0].cyc == cyc) begin
            chk("missed_strobe", int'({wr_b, wr_g, wr_r}), q[0].mask);
        end
    end

    task automatic drive(input bit en, input int d, input int m);
        in_en    = en;
        data_in  = d[7:0];
        cfa_mode = m[1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int m, input bit abort);
        rec_t r;
        int   t, last_e, got, c;
        bit   seen;
        last_e = 0;
        for (int i = 0; i < N; i++) begin
            if (i == 7) repeat (3) drive(1'b0, $urandom, $urandom);
            else if (i > 0 && $urandom_range(0, 4) == 0)
                repeat ($urandom_range(1, 3)) drive(1'b0, $urandom, $urandom);
            c = col(i % W, i / W, m);
            r.cyc = cyc + 1; r.mask = 1 << c; r.addr = i;
            r.dr = (c == 0) ? raw[i] : 0;
            r.dg = (c == 1) ? raw[i] : 0;
            r.db = (c == 2) ? raw[i] : 0;
            q.push_back(r);
            if (i == N-1) last_e = cyc + 1;
            drive(1'b1, raw[i], (i == 0) ? m : int'($urandom_range(0, 3)));
            if (i == 0) begin
                chk("busy_after_start", int'(busy), 1);
                chk("done_after_start", int'(done), 0);
            end
        end
        t = last_e;
        for (int i = 0; i < N; i++) begin
            c = col(i % W, i / W, m);
            t += (c == 1) ? 3 : 5;
            r.cyc = t - 1; r.mask = 7 & ~(1 << c); r.addr = i;
            r.dr = (c != 0) ? model_val(i % W, i / W, 0, m) : 0;
            r.dg = (c != 1) ? model_val(i % W, i / W, 1, m) : 0;
            r.db = (c != 2) ? model_val(i % W, i / W, 2, m) : 0;
            q.push_back(r);
        end
        if (abort) begin
            repeat (20) drive(1'b0, $urandom, $urandom);
            #2 reset = 1'b1;
            #1;
            chk("abort_wr", int'({wr_r, wr_g, wr_b}), 0);
            chk("abort_addr", int'({addr_r, addr_g, addr_b}), 0);
            chk("abort_wdata", int'({wdata_r, wdata_g, wdata_b}), 0);
            chk("abort_busy", int'(busy), 0);
            chk("abort_done", int'(done), 0);
            q.delete();
            repeat (3) @(posedge clk);
            #1 reset = 1'b0;
            return;
        end
        seen = 1'b0;
        got  = 0;
        for (int j = 0; j < 300 && !seen; j++) begin
            drive((j < 40) ? bit'($urandom_range(0, 1)) : 1'b0, $urandom, $urandom);
            if (done) begin seen = 1'b1; got = cyc; end
        end
        chk("done_seen", int'(seen), 1);
        if (seen) chk("done_latency", got - last_e, 64);
        chk("busy_at_done", int'(busy), 0);
        chk("queue_drained", q.size(), 0);
        for (int i = 0; i < N; i++) begin
            chk("mem_r", int'(mem_r[i]), model_val(i % W, i / W, 0, m));
            chk("mem_g", int'(mem_g[i]), model_val(i % W, i / W, 1, m));
            chk("mem_b", int'(mem_b[i]), model_val(i % W, i / W, 2, m));
        end
        repeat (3) drive(1'b0, $urandom, $urandom);
        chk("done_held", int'(done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_en = 1'b0; data_in = '0; cfa_mode = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr", int'({wr_r, wr_g, wr_b}), 0);
        chk("rst_addr", int'({addr_r, addr_g, addr_b}), 0);
        chk("rst_wdata", int'({wdata_r, wdata_g, wdata_b}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;

        foreach (raw[i]) raw[i] = 100;
        chk("model_flat", model_val(0, 0, 1, 0), 100);
        run_frame(0, 1'b0);

        foreach (raw[i]) raw[i] = $urandom_range(0, 255);
        raw[1] = 10; raw[4] = 30; raw[5] = 50;
        chk("model_corner_g", model_val(0, 0, 1, 0), 20);
        chk("model_corner_b", model_val(0, 0, 2, 0), 50);
        run_frame(0, 1'b0);

        foreach (raw[i]) raw[i] = $urandom_range(0, 255);
        raw[0] = 1; raw[2] = 2;
        chk("model_round_g", model_val(1, 0, 0, 0), 2);
        run_frame(0, 1'b0);

        foreach (raw[i]) raw[i] = 255;
        chk("model_sat", model_val(1, 1, 0, 2), 255);
        run_frame(2, 1'b0);

        foreach (raw[i]) raw[i] = $urandom_range(0, 255);
        raw[0] = 77;
        chk("model_bggr_p0", col(0, 0, 3), 2);
        run_frame(3, 1'b0);

        foreach (raw[i]) raw[i] = $urandom_range(0, 255);
        chk("model_grbg_p1", col(1, 0, 1), 0);
        run_frame(1, 1'b0);

        foreach (raw[i]) raw[i] = $urandom_range(0, 255);
        run_frame($urandom_range(0, 3), 1'b1);

        for (int f = 0; f < 4; f++) begin
            foreach (raw[i]) raw[i] = $urandom_range(0, 255);
            run_frame($urandom_range(0, 3), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
